// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant codes and
// default address/data widths.
package mem_arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

endpackage

// File: rtl/arb_pick.sv
// Two-way winner select between fetch and data; fetch_prio decides ties so the
// tie-break policy lives outside the FSM.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic fetch_elig,
    input  logic data_elig,
    input  logic fetch_prio,
    output gnt_t gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (fetch_elig && data_elig) begin
            gnt = fetch_prio ? GNT_I : GNT_D;
        end else if (fetch_elig) begin
            gnt = GNT_I;
        end else if (data_elig) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise data always wins ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_flush,
    output logic [DW-1:0]   i_rdata,
    output logic            i_valid,
    output logic            i_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_valid,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready
);

    // state     | meaning
    // ST_IDLE   | nothing on memory; arbitrate among eligible requests
    // ST_BUSY_I | fetch access on memory, waiting for mem_ready
    // ST_BUSY_D | load/store access on memory, waiting for mem_ready

    logic [1:0]      state;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] be_q;
    logic            we_q;
    logic            drop_q;
    logic            fetch_prio;
    gnt_t            gnt;

    // A port is masked in the cycle its previous access is reported complete.
    arb_pick u_pick (
        .fetch_elig (i_req & ~i_valid),
        .data_elig  (d_req & ~d_valid),
        .fetch_prio (fetch_prio),
        .gnt        (gnt)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_fetch;  // 1: fetch wins the next tie
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_fetch <= 1'b0;
        end else if (state == ST_IDLE && gnt != GNT_NONE) begin
            rr_fetch <= (gnt == GNT_D);
        end
    end
    assign fetch_prio = rr_fetch;
`else
    assign fetch_prio = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            i_rdata <= '0;
            i_valid <= 1'b0;
            d_rdata <= '0;
            d_valid <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt == GNT_I) begin
                        addr_q  <= i_addr;
                        wdata_q <= '0;
                        be_q    <= '1;
                        we_q    <= 1'b0;
                        state   <= ST_BUSY_I;
                    end else if (gnt == GNT_D) begin
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        be_q    <= d_we ? d_be : '1;
                        we_q    <= d_we;
                        state   <= ST_BUSY_D;
                    end
                end
                ST_BUSY_I: begin
                    // A redirected fetch still completes on memory but is never reported.
                    if (mem_ready) begin
                        if (!(drop_q || i_flush)) begin
                            i_rdata <= mem_rdata;
                            i_valid <= 1'b1;
                        end
                        drop_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ready) begin
                        if (!we_q) begin
                            d_rdata <= mem_rdata;
                        end
                        d_valid <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    assign mem_we    = (state == ST_BUSY_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign i_stall = i_req & ~i_valid;
    assign d_stall = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        i_req, i_flush, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_valid, i_stall, d_valid, d_stall, mem_req, mem_we;
    logic [3:0]  mem_be;

    mem_port_arbiter dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: expected outputs for the cycle about to be sampled
    logic        x_mreq, x_owner_d, x_we, x_iv, x_dv, flushed, last_d;
    logic [31:0] x_addr, x_wdata, x_irdata, x_drdata, last_rdata;
    logic [3:0]  x_be;
    logic        o_mreq, o_iv, o_dv, idle_ready;
    int          cnt, lat_next;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        x_mreq = 0; x_owner_d = 0; x_we = 0; x_iv = 0; x_dv = 0; flushed = 0;
        last_d = 0;  // data is served first on the first tie after reset
        x_addr = 0; x_wdata = 0; x_be = 0; x_irdata = 0; x_drdata = 0;
        o_mreq = 0; o_iv = 0; o_dv = 0; cnt = 0;
    endtask

    // Close the current cycle in the model, advance to the next negedge, check,
    // then drive the memory side for the new cycle.
    task automatic cyc();
        logic ei, ed, win_d, pm;
        pm = o_mreq;
        x_iv = 0;
        x_dv = 0;
        if (o_mreq) begin
            if (mem_ready) begin
                if (!x_owner_d) begin
                    if (!(flushed || i_flush)) begin
                        x_iv = 1;
                        x_irdata = mem_rdata;
                    end
                    flushed = 0;
                end else begin
                    x_dv = 1;
                    if (!x_we) x_drdata = mem_rdata;
                end
                x_mreq = 0;
            end else if (!x_owner_d && i_flush) begin
                flushed = 1;
            end
        end else begin
            ei = i_req && !o_iv;
            ed = d_req && !o_dv;
            if (ei || ed) begin
`ifdef ARB_ROUND_ROBIN_EN
                win_d = (ei && ed) ? !last_d : ed;
`else
                win_d = ed;
`endif
                last_d    = win_d;
                x_mreq    = 1;
                x_owner_d = win_d;
                x_addr    = win_d ? d_addr : i_addr;
                x_we      = win_d ? d_we : 1'b0;
                x_be      = (win_d && d_we) ? d_be : 4'hF;
                x_wdata   = d_wdata;
            end
        end
        @(negedge clk);
        chk("mem_req", mem_req, x_mreq);
        if (x_mreq) begin
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_we", mem_we, x_owner_d && x_we);
            chk("mem_be", mem_be, x_be);
            if (x_owner_d && x_we) chk("mem_wdata", mem_wdata, x_wdata);
        end
        chk("i_valid", i_valid, x_iv);
        chk("d_valid", d_valid, x_dv);
        chk("i_rdata", i_rdata, x_irdata);
        chk("d_rdata", d_rdata, x_drdata);
        chk("i_stall", i_stall, i_req && !x_iv);
        chk("d_stall", d_stall, d_req && !x_dv);
        o_mreq = x_mreq;
        o_iv   = x_iv;
        o_dv   = x_dv;
        if (x_mreq) begin
            if (!pm) cnt = lat_next;
            if (cnt == 0) begin
                mem_ready  = 1;
                mem_rdata  = $urandom;
                last_rdata = mem_rdata;
            end else begin
                mem_ready = 0;
                cnt--;
            end
        end else begin
            mem_ready = idle_ready;
            mem_rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        #2;
        rstn = 0;
        i_req = 0; i_flush = 0; d_req = 0; d_we = 0; mem_ready = 0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_valids", {i_valid, d_valid}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_stalls", {i_stall, d_stall}, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rstn = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy, pulses, ng, n_done;
        logic got, prev;
        logic [31:0] last_maddr, keep;
        logic gd [8];

        rstn = 1; i_req = 0; i_addr = 0; i_flush = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0; mem_ready = 0;
        idle_ready = 0; lat_next = 0; last_rdata = 0;
        model_clear();
        do_reset();

        // single fetch, minimum latency
        i_req = 1; i_addr = 32'h100; lat_next = 0;
        cyc();
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_be", mem_be, 4'hF);
        cyc();
        chk("fetch_valid", i_valid, 1);
        chk("fetch_rdata", i_rdata, last_rdata);
        chk("fetch_stall", i_stall, 0);
        i_req = 0;
        repeat (2) cyc();

        // both ports held high: grants must alternate D,I,D,I,...
        i_req = 1; i_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h2000;
        ng = 0; prev = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (mem_req && !prev && ng < 8) begin
                gd[ng] = (mem_addr == 32'h2000);
                ng++;
            end
            prev = mem_req;
        end
        chk("grant_count", ng, 8);
        for (int k = 0; k < 8; k++) chk($sformatf("grant%0d_is_data", k), gd[k], (k % 2) == 0);
        i_req = 0; d_req = 0;
        repeat (4) cyc();

        // store with three-cycle memory access
        keep = d_rdata;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        lat_next = 2; busy = 0; pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (mem_req) busy++;
            if (d_valid) begin
                pulses++;
                d_req = 0;
            end
        end
        chk("store_busy_cycles", busy, 3);
        chk("store_valid_pulses", pulses, 1);
        chk("store_rdata_kept", d_rdata, keep);
        d_we = 0;

        // redirect during fetch of 0x8; the next fetch at 0x20 returns its own data
        i_req = 1; i_addr = 32'h8; lat_next = 2;
        cyc();
        i_flush = 1; i_addr = 32'h20;
        cyc();
        i_flush = 0;
        got = 0; last_maddr = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (mem_req) last_maddr = mem_addr;
            if (i_valid && !got) begin
                got = 1;
                chk("flush_next_addr", last_maddr, 32'h20);
                chk("flush_next_rdata", i_rdata, last_rdata);
                i_req = 0;
            end
        end
        chk("flush_next_served", got, 1);

        // reset in the middle of a load
        d_req = 1; d_we = 0; d_addr = 32'h3000; lat_next = 5;
        repeat (3) cyc();
        chk("pre_reset_busy", mem_req, 1);
        do_reset();
        repeat (5) cyc();
        d_req = 1; d_addr = 32'h3000; lat_next = 1; got = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (d_valid && !got) begin
                got = 1;
                chk("post_reset_rdata", d_rdata, last_rdata);
                d_req = 0;
            end
        end
        chk("post_reset_served", got, 1);

        // mem_ready while idle is ignored
        idle_ready = 1;
        repeat (3) cyc();
        chk("idle_ready_no_req", mem_req, 0);
        idle_ready = 0;

        // random traffic
        n_done = 0;
        for (int k = 0; k < 2000; k++) begin
            lat_next   = $urandom_range(0, 3);
            idle_ready = $urandom_range(0, 1);
            cyc();
            if (i_valid || d_valid) n_done++;
            if (i_valid || !i_req) begin
                i_req  = ($urandom_range(0, 2) == 0);
                i_addr = $urandom & 32'h0000_0FFC;
            end
            i_flush = i_req && ($urandom_range(0, 9) == 0);
            if (i_flush) i_addr = $urandom & 32'h0000_0FFC;
            if (d_valid || !d_req) begin
                d_req   = $urandom_range(0, 1);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom & 32'h0001_FFFC;
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(1, 15));
            end
        end
        chk("random_progress", n_done > 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
